// File: rtl/spi_slave_bridge_p.sv
// SPI slave bridge: the SPI pins are oversampled in the clk domain, so nothing is clocked by sclk.
// Supports parametrised word width, all four SPI modes, bit order, and a valid/ready TX side.
module spi_slave_bridge_p #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy
);
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int S     = SYNC_STAGES;

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [S-1:0]      sclk_q, cs_q, mosi_q;
  logic [DATA_W-1:0] rx_sh, tx_sh, rx_next, load_word;
  logic [CNT_W-1:0]  bit_cnt;
  logic              miso_r;
  logic              act, lead, trail, cs_fall, cs_rise, mosi_s;
  logic              sample_e, shift_e, last_bit, entry, load;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= {S{1'(CPOL)}};
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[S-2:0], sclk};
      cs_q   <= {cs_q[S-2:0], cs_n};
      mosi_q <= {mosi_q[S-2:0], mosi};
    end
  end

  // Edges come from the last two stages; stage S-2 is the newer value.
  assign lead     = (sclk_q[S-2] ^ sclk_q[S-1]) & (sclk_q[S-2] != 1'(CPOL));
  assign trail    = (sclk_q[S-2] ^ sclk_q[S-1]) & (sclk_q[S-2] == 1'(CPOL));
  assign cs_fall  = cs_q[S-1] & ~cs_q[S-2];
  assign cs_rise  = ~cs_q[S-1] & cs_q[S-2];
  assign mosi_s   = mosi_q[S-1];

  assign act       = (state == ACTIVE);
  assign sample_e  = act & ~cs_rise & ((CPHA != 0) ? trail : lead);
  assign shift_e   = act & ~cs_rise & ((CPHA != 0) ? lead : trail);
  assign last_bit  = (bit_cnt == CNT_W'(DATA_W-1));
  assign entry     = (state == IDLE) & cs_fall;
  assign load      = entry | (sample_e & last_bit);
  assign load_word = tx_valid ? tx_data : '0;
  assign rx_next   = (MSB_FIRST != 0) ? {rx_sh[DATA_W-2:0], mosi_s}
                                      : {mosi_s, rx_sh[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = act;
    miso_oe     = act;
    miso        = act & miso_r;
    tx_ready    = load & tx_valid;
    tx_underrun = load & ~tx_valid;
    frame_abort = act & cs_rise & (bit_cnt != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh    <= '0;
      tx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      bit_cnt  <= '0;
      miso_r   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (entry) begin
        bit_cnt <= '0;
        rx_sh   <= '0;
      end else if (!act || cs_rise) begin
        bit_cnt <= '0;
      end else if (sample_e) begin
        rx_sh <= rx_next;
        if (last_bit) begin
          bit_cnt  <= '0;
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      // CPHA=0 presents bit 0 at load, so the shift edge right after a
      // word completion (bit_cnt already wrapped) must not advance.
      if (load) begin
        if (CPHA == 0) begin
          miso_r <= first_bit(load_word);
          tx_sh  <= advance(load_word);
        end else begin
          tx_sh  <= load_word;
        end
      end else if (shift_e && (CPHA != 0 || bit_cnt != '0)) begin
        miso_r <= first_bit(tx_sh);
        tx_sh  <= advance(tx_sh);
      end else if (!act) begin
        miso_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_bridge_p.sv
// Directed bench: instance 0 is 8-bit mode 0 MSB-first, instances 1..4 are
// 16-bit LSB-first in modes 0..3; a behavioural SPI master drives each.
module tb_spi_slave_bridge_p;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic sclk [5], cs_n [5], mosi [5], miso [5], miso_oe [5];
  logic rx_valid [5], tx_valid [5], tx_ready [5], tx_underrun [5], frame_abort [5], busy [5];
  logic [7:0]  rx8, tx8;
  logic [15:0] rx16 [1:4];
  logic [15:0] tx16 [1:4];

  int checks = 0, failures = 0;
  int rxv_cnt [5] = '{0, 0, 0, 0, 0};
  int rdy_cnt [5] = '{0, 0, 0, 0, 0};
  int und_cnt [5] = '{0, 0, 0, 0, 0};
  int abt_cnt [5] = '{0, 0, 0, 0, 0};

  spi_slave_bridge_p #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]),
    .miso(miso[0]), .miso_oe(miso_oe[0]), .rx_data(rx8), .rx_valid(rx_valid[0]),
    .tx_data(tx8), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .tx_underrun(tx_underrun[0]), .frame_abort(frame_abort[0]), .busy(busy[0]));

  for (genvar g = 1; g <= 4; g++) begin : g_mode
    spi_slave_bridge_p #(.DATA_W(16), .CPOL((g-1)/2), .CPHA((g-1)%2), .MSB_FIRST(0), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk[g]), .cs_n(cs_n[g]), .mosi(mosi[g]),
      .miso(miso[g]), .miso_oe(miso_oe[g]), .rx_data(rx16[g]), .rx_valid(rx_valid[g]),
      .tx_data(tx16[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .tx_underrun(tx_underrun[g]), .frame_abort(frame_abort[g]), .busy(busy[g]));
  end

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rx_valid[i])    rxv_cnt[i] <= rxv_cnt[i] + 1;
      if (tx_ready[i])    rdy_cnt[i] <= rdy_cnt[i] + 1;
      if (tx_underrun[i]) und_cnt[i] <= und_cnt[i] + 1;
      if (frame_abort[i]) abt_cnt[i] <= abt_cnt[i] + 1;
    end
  end

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_low(input int d);
    cs_n[d] = 1'b0;
    half();
  endtask

  task automatic cs_high(input int d);
    cs_n[d] = 1'b1;
    half();
    half();
  endtask

  // SPI master: transfers 'stop' of 'nb' bits, returns what it captured on miso.
  task automatic xfer(input int d, input int nb, input int stop, input logic [15:0] mo,
                      output logic [15:0] mi);
    logic cp, ph, msb;
    int idx;
    cp  = (d == 0) ? 1'b0 : 1'(((d - 1) / 2) % 2);
    ph  = (d == 0) ? 1'b0 : 1'((d - 1) % 2);
    msb = (d == 0);
    mi  = '0;
    if (!ph) begin
      mosi[d] = mo[msb ? nb - 1 : 0];
      half();
    end
    for (int k = 0; k < stop; k++) begin
      idx = msb ? nb - 1 - k : k;
      if (!ph) begin
        mi[idx] = miso[d];
        sclk[d] = ~cp;
        half();
        sclk[d] = cp;
        if (k + 1 < nb) mosi[d] = mo[msb ? idx - 1 : idx + 1];
        half();
      end else begin
        sclk[d] = ~cp;
        mosi[d] = mo[idx];
        half();
        mi[idx] = miso[d];
        sclk[d] = cp;
        half();
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (rx8 !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=%h", rx8, 8'h00); end
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy[0]); end
    checks++; if (miso_oe[0] !== 1'b0 || miso[0] !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b/%b exp=0/0", miso_oe[0], miso[0]); end
    checks++; if ({rx_valid[0], tx_ready[0], tx_underrun[0], frame_abort[0]} !== 4'b0) begin
      failures++; $display("FAIL reset_pulses got=%b exp=0000", {rx_valid[0], tx_ready[0], tx_underrun[0], frame_abort[0]}); end
  endtask

  task automatic test_mode0();
    logic [15:0] mi;
    int rv, rd;
    rv = rxv_cnt[0]; rd = rdy_cnt[0];
    tx8 = 8'hA5; tx_valid[0] = 1'b1;
    cs_low(0);
    tx_valid[0] = 1'b0;
    checks++; if (busy[0] !== 1'b1 || miso_oe[0] !== 1'b1) begin failures++; $display("FAIL mode0_busy got=%b/%b exp=1/1", busy[0], miso_oe[0]); end
    xfer(0, 8, 8, 16'h003C, mi);
    checks++; if (mi[7:0] !== 8'hA5) begin failures++; $display("FAIL mode0_miso got=%h exp=%h", mi[7:0], 8'hA5); end
    checks++; if (rx8 !== 8'h3C) begin failures++; $display("FAIL mode0_rx got=%h exp=%h", rx8, 8'h3C); end
    checks++; if (rxv_cnt[0] - rv !== 1) begin failures++; $display("FAIL mode0_rx_valid got=%0d exp=1", rxv_cnt[0] - rv); end
    checks++; if (rdy_cnt[0] - rd !== 1) begin failures++; $display("FAIL mode0_tx_ready got=%0d exp=1", rdy_cnt[0] - rd); end
    cs_high(0);
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL mode0_idle got=%b exp=0", busy[0]); end
  endtask

  task automatic test_modes16();
    logic [15:0] mi;
    for (int d = 1; d <= 4; d++) begin
      tx16[d] = 16'h1234; tx_valid[d] = 1'b1;
      cs_low(d);
      tx_valid[d] = 1'b0;
      xfer(d, 16, 16, 16'hBEEF, mi);
      cs_high(d);
      checks++; if (rx16[d] !== 16'hBEEF) begin failures++; $display("FAIL mode%0d_rx got=%h exp=%h", d - 1, rx16[d], 16'hBEEF); end
      checks++; if (mi !== 16'h1234) begin failures++; $display("FAIL mode%0d_miso got=%h exp=%h", d - 1, mi, 16'h1234); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] mi1, mi2, mi3;
    int rv, rd;
    rv = rxv_cnt[0]; rd = rdy_cnt[0];
    tx8 = 8'h5A; tx_valid[0] = 1'b1;
    cs_low(0);
    xfer(0, 8, 8, 16'h0011, mi1);
    xfer(0, 8, 8, 16'h0022, mi2);
    checks++; if (rdy_cnt[0] - rd !== 3) begin failures++; $display("FAIL b2b_tx_ready got=%0d exp=3", rdy_cnt[0] - rd); end
    xfer(0, 8, 8, 16'h0033, mi3);
    tx_valid[0] = 1'b0;
    cs_high(0);
    checks++; if (rxv_cnt[0] - rv !== 3) begin failures++; $display("FAIL b2b_rx_valid got=%0d exp=3", rxv_cnt[0] - rv); end
    checks++; if (rx8 !== 8'h33) begin failures++; $display("FAIL b2b_rx got=%h exp=%h", rx8, 8'h33); end
    checks++; if (mi1[7:0] !== 8'h5A || mi2[7:0] !== 8'h5A || mi3[7:0] !== 8'h5A) begin
      failures++; $display("FAIL b2b_miso got=%h/%h/%h exp=5a/5a/5a", mi1[7:0], mi2[7:0], mi3[7:0]); end
  endtask

  task automatic test_underrun();
    logic [15:0] mi;
    int un, rd, rv;
    un = und_cnt[0]; rd = rdy_cnt[0]; rv = rxv_cnt[0];
    tx8 = 8'hFF; tx_valid[0] = 1'b0;
    cs_low(0);
    checks++; if (und_cnt[0] - un !== 1) begin failures++; $display("FAIL underrun_pulse got=%0d exp=1", und_cnt[0] - un); end
    checks++; if (rdy_cnt[0] - rd !== 0) begin failures++; $display("FAIL underrun_ready got=%0d exp=0", rdy_cnt[0] - rd); end
    xfer(0, 8, 8, 16'h0081, mi);
    cs_high(0);
    checks++; if (mi[7:0] !== 8'h00) begin failures++; $display("FAIL underrun_miso got=%h exp=%h", mi[7:0], 8'h00); end
    checks++; if (rx8 !== 8'h81 || rxv_cnt[0] - rv !== 1) begin failures++; $display("FAIL underrun_rx got=%h/%0d exp=81/1", rx8, rxv_cnt[0] - rv); end
  endtask

  task automatic test_abort();
    logic [15:0] mi;
    int ab, rv;
    ab = abt_cnt[0]; rv = rxv_cnt[0];
    tx8 = 8'hA5; tx_valid[0] = 1'b1;
    cs_low(0);
    tx_valid[0] = 1'b0;
    xfer(0, 8, 5, 16'h00FF, mi);
    cs_high(0);
    checks++; if (abt_cnt[0] - ab !== 1) begin failures++; $display("FAIL abort_pulse got=%0d exp=1", abt_cnt[0] - ab); end
    checks++; if (rxv_cnt[0] - rv !== 0) begin failures++; $display("FAIL abort_rx_valid got=%0d exp=0", rxv_cnt[0] - rv); end
    checks++; if (rx8 !== 8'h81) begin failures++; $display("FAIL abort_rx_hold got=%h exp=%h", rx8, 8'h81); end
    tx8 = 8'hA5; tx_valid[0] = 1'b1;
    cs_low(0);
    tx_valid[0] = 1'b0;
    xfer(0, 8, 8, 16'h006B, mi);
    cs_high(0);
    checks++; if (rx8 !== 8'h6B) begin failures++; $display("FAIL abort_next_rx got=%h exp=%h", rx8, 8'h6B); end
    checks++; if (mi[7:0] !== 8'hA5) begin failures++; $display("FAIL abort_next_miso got=%h exp=%h", mi[7:0], 8'hA5); end
    checks++; if (abt_cnt[0] - ab !== 1) begin failures++; $display("FAIL abort_clean_frame got=%0d exp=1", abt_cnt[0] - ab); end
  endtask

  task automatic test_reset_midword();
    logic [15:0] mi;
    tx8 = 8'hA5; tx_valid[0] = 1'b1;
    cs_low(0);
    tx_valid[0] = 1'b0;
    xfer(0, 8, 4, 16'h00FF, mi);
    rst_n = 1'b0;
    #1;
    checks++; if (busy[0] !== 1'b0 || miso_oe[0] !== 1'b0 || miso[0] !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got=%b%b%b exp=000", busy[0], miso_oe[0], miso[0]); end
    checks++; if (rx8 !== 8'h00 || rx_valid[0] !== 1'b0) begin failures++; $display("FAIL rstmid_rx got=%h/%b exp=00/0", rx8, rx_valid[0]); end
    cs_n[0] = 1'b1; sclk[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tx8 = 8'h3C; tx_valid[0] = 1'b1;
    cs_low(0);
    tx_valid[0] = 1'b0;
    xfer(0, 8, 8, 16'h00C3, mi);
    cs_high(0);
    checks++; if (rx8 !== 8'hC3) begin failures++; $display("FAIL rstmid_rx_after got=%h exp=%h", rx8, 8'hC3); end
    checks++; if (mi[7:0] !== 8'h3C) begin failures++; $display("FAIL rstmid_miso_after got=%h exp=%h", mi[7:0], 8'h3C); end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sclk[i] = (i == 3 || i == 4) ? 1'b1 : 1'b0;
      cs_n[i] = 1'b1; mosi[i] = 1'b0; tx_valid[i] = 1'b0;
    end
    tx8 = '0;
    for (int i = 1; i <= 4; i++) tx16[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_mode0();
    test_modes16();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
